// File: rtl/uparc_memory_access_pkg.sv
// Shared LSU operation codes, memory-stage FSM states and alignment helper
// for the uparc memory access stage.
package uparc_memory_access_pkg;

    localparam int UPARC_LSUOP_WIDTH = 2;

    localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSU_IDLE  = 2'd0;
    localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSU_BYTE  = 2'd1;
    localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSU_HWORD = 2'd2;
    localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSU_WORD  = 2'd3;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_BUSY = 2'd1,
        MA_DONE = 2'd2
    } ma_state_t;

    // True when the access size does not fit the low address bits.
    function automatic logic lsu_misaligned(input logic [UPARC_LSUOP_WIDTH-1:0] op,
                                            input logic [1:0] addr_lo);
        return ((op == UPARC_LSU_HWORD) && addr_lo[0]) ||
               ((op == UPARC_LSU_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/uparc_memory_access_lsu_fmt.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads (little-endian, lane = addr[1:0]).
module uparc_lsu_fmt
    import uparc_memory_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_st_op,
    input  logic [1:0]        i_st_addr_lo,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [3:0]        o_st_ben,
    output logic [DATA_W-1:0] o_st_wdata,
    input  logic [1:0]        i_ld_op,
    input  logic [1:0]        i_ld_addr_lo,
    input  logic              i_ld_ext,
    input  logic [DATA_W-1:0] i_ld_rdata,
    output logic [DATA_W-1:0] o_ld_value
);

    function automatic void store_steer(input  logic [1:0]        op,
                                        input  logic [1:0]        addr_lo,
                                        input  logic [DATA_W-1:0] data,
                                        output logic [3:0]        ben,
                                        output logic [DATA_W-1:0] wdata);
        ben   = 4'b0000;
        wdata = data;
        case (op)
            UPARC_LSU_BYTE: begin
                ben   = 4'b0001 << addr_lo;
                wdata = {(DATA_W/8){data[7:0]}};
            end
            UPARC_LSU_HWORD: begin
                ben   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {(DATA_W/16){data[15:0]}};
            end
            UPARC_LSU_WORD: ben = 4'b1111;
            default: ben = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [1:0]        op,
                                                       input logic [1:0]        addr_lo,
                                                       input logic              ext,
                                                       input logic [DATA_W-1:0] rdata);
        logic [7:0]        w_byte;
        logic [15:0]       w_half;
        logic [DATA_W-1:0] w_val;
        w_byte = rdata[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            UPARC_LSU_BYTE:  w_val = {{(DATA_W-8){ext & w_byte[7]}}, w_byte};
            UPARC_LSU_HWORD: w_val = {{(DATA_W-16){ext & w_half[15]}}, w_half};
            default:         w_val = rdata;
        endcase
        return w_val;
    endfunction

    always_comb begin
        store_steer(i_st_op, i_st_addr_lo, i_st_data, o_st_ben, o_st_wdata);
        o_ld_value = load_extract(i_ld_op, i_ld_addr_lo, i_ld_ext, i_ld_rdata);
    end

endmodule

// File: rtl/uparc_memory_access.sv
// Memory access stage: single-outstanding load/store bus transactions with
// pipeline stall. Optional misalignment trap: UPARC_LSU_MISALIGN_TRAP_EN.
module uparc_memory_access
    import uparc_memory_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int REGNO_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_exec_stall,
    input  logic               i_fetch_stall,
    input  logic               i_wait_stall,
    output logic               o_mem_stall,
    output logic               o_addr_error,
    input  logic [REGNO_W-1:0] i_rd_no,
    input  logic [DATA_W-1:0]  i_alu_result,
    input  logic [1:0]         i_lsu_op,
    input  logic               i_lsu_lns,
    input  logic               i_lsu_ext,
    input  logic [DATA_W-1:0]  i_mem_data,
    output logic               o_bus_req,
    output logic [ADDR_W-1:0]  o_bus_addr,
    output logic               o_bus_wr,
    output logic [3:0]         o_bus_ben,
    output logic [DATA_W-1:0]  o_bus_wdata,
    input  logic               i_bus_ack,
    input  logic [DATA_W-1:0]  i_bus_rdata,
    output logic [REGNO_W-1:0] o_rd_no,
    output logic [DATA_W-1:0]  o_rd_val
);

    ma_state_t          r_state;
    logic               r_bus_req;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic               r_bus_wr;
    logic [3:0]         r_bus_ben;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic [REGNO_W-1:0] r_rd_no;
    logic [DATA_W-1:0]  r_rd_val;
    logic [DATA_W-1:0]  r_load_data;
    logic [1:0]         r_op;
    logic [1:0]         r_addr_lo;
    logic               r_lns;
    logic               r_ext;
`ifdef UPARC_LSU_MISALIGN_TRAP_EN
    logic               r_addr_error;
`endif

    logic               w_other_stall;
    logic               w_op_req;
    logic               w_trap;
    logic               w_mem_stall;
    logic [3:0]         w_st_ben;
    logic [DATA_W-1:0]  w_st_wdata;
    logic [DATA_W-1:0]  w_ld_value;

    assign w_other_stall = i_exec_stall | i_fetch_stall | i_wait_stall;
    assign w_op_req      = (i_lsu_op != UPARC_LSU_IDLE);

`ifdef UPARC_LSU_MISALIGN_TRAP_EN
    assign w_trap       = w_op_req && lsu_misaligned(i_lsu_op, i_alu_result[1:0]);
    assign o_addr_error = r_addr_error;
`else
    assign w_trap       = 1'b0;
    assign o_addr_error = 1'b0;
`endif

    // A trapped access never reaches the bus, so it must not freeze the pipeline.
    always_comb begin
        w_mem_stall = 1'b0;
        case (r_state)
            MA_IDLE: w_mem_stall = w_op_req && !w_trap;
            MA_BUSY: w_mem_stall = 1'b1;
            default: w_mem_stall = 1'b0;
        endcase
    end

    assign o_mem_stall = w_mem_stall;

    uparc_lsu_fmt #(
        .DATA_W (DATA_W)
    ) u_fmt (
        .i_st_op      (i_lsu_op),
        .i_st_addr_lo (i_alu_result[1:0]),
        .i_st_data    (i_mem_data),
        .o_st_ben     (w_st_ben),
        .o_st_wdata   (w_st_wdata),
        .i_ld_op      (r_op),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_ext     (r_ext),
        .i_ld_rdata   (i_bus_rdata),
        .o_ld_value   (w_ld_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MA_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wr    <= 1'b0;
            r_bus_ben   <= 4'b0000;
            r_bus_wdata <= '0;
            r_rd_no     <= '0;
            r_rd_val    <= '0;
            r_load_data <= '0;
            r_op        <= UPARC_LSU_IDLE;
            r_addr_lo   <= 2'b00;
            r_lns       <= 1'b0;
            r_ext       <= 1'b0;
`ifdef UPARC_LSU_MISALIGN_TRAP_EN
            r_addr_error <= 1'b0;
`endif
        end else begin
`ifdef UPARC_LSU_MISALIGN_TRAP_EN
            r_addr_error <= 1'b0;
`endif
            case (r_state)
                MA_IDLE: begin
                    if (!w_other_stall) begin
                        if (!w_op_req) begin
                            r_rd_no  <= i_rd_no;
                            r_rd_val <= i_alu_result;
                        end else if (w_trap) begin
                            r_rd_no <= '0;
`ifdef UPARC_LSU_MISALIGN_TRAP_EN
                            r_addr_error <= 1'b1;
`endif
                        end else begin
                            // Keep the access shape for formatting the read data later.
                            r_state     <= MA_BUSY;
                            r_bus_req   <= 1'b1;
                            r_bus_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
                            r_bus_wr    <= i_lsu_lns;
                            r_bus_ben   <= i_lsu_lns ? w_st_ben : 4'b1111;
                            r_bus_wdata <= i_lsu_lns ? w_st_wdata : '0;
                            r_op        <= i_lsu_op;
                            r_addr_lo   <= i_alu_result[1:0];
                            r_lns       <= i_lsu_lns;
                            r_ext       <= i_lsu_ext;
                        end
                    end
                end
                MA_BUSY: begin
                    if (i_bus_ack) begin
                        r_bus_req   <= 1'b0;
                        r_load_data <= w_ld_value;
                        r_state     <= MA_DONE;
                    end
                end
                MA_DONE: begin
                    if (!w_other_stall) begin
                        if (r_lns) begin
                            r_rd_no <= '0;
                        end else begin
                            r_rd_no  <= i_rd_no;
                            r_rd_val <= r_load_data;
                        end
                        r_state <= MA_IDLE;
                    end
                end
                default: r_state <= MA_IDLE;
            endcase
        end
    end

    assign o_bus_req   = r_bus_req;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wr    = r_bus_wr;
    assign o_bus_ben   = r_bus_ben;
    assign o_bus_wdata = r_bus_wdata;
    assign o_rd_no     = r_rd_no;
    assign o_rd_val    = r_rd_val;

endmodule

// File: tb/tb_uparc_memory_access.sv
// Scoreboard bench for uparc_memory_access: random instruction stream with a
// behavioural reference model, bus responder with random ack latency.
module tb_uparc_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_fetch_stall, i_wait_stall;
    logic        o_mem_stall, o_addr_error;
    logic [4:0]  i_rd_no;
    logic [31:0] i_alu_result;
    logic [1:0]  i_lsu_op;
    logic        i_lsu_lns, i_lsu_ext;
    logic [31:0] i_mem_data;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic        o_bus_wr;
    logic [3:0]  o_bus_ben;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;

    always #5 clk = ~clk;

    uparc_memory_access #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .REGNO_W (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_exec_stall  (i_exec_stall),
        .i_fetch_stall (i_fetch_stall),
        .i_wait_stall  (i_wait_stall),
        .o_mem_stall   (o_mem_stall),
        .o_addr_error  (o_addr_error),
        .i_rd_no       (i_rd_no),
        .i_alu_result  (i_alu_result),
        .i_lsu_op      (i_lsu_op),
        .i_lsu_lns     (i_lsu_lns),
        .i_lsu_ext     (i_lsu_ext),
        .i_mem_data    (i_mem_data),
        .o_bus_req     (o_bus_req),
        .o_bus_addr    (o_bus_addr),
        .o_bus_wr      (o_bus_wr),
        .o_bus_ben     (o_bus_ben),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ack     (i_bus_ack),
        .i_bus_rdata   (i_bus_rdata),
        .o_rd_no       (o_rd_no),
        .o_rd_val      (o_rd_val)
    );

    typedef struct packed {
        logic [4:0]  rdNo;
        logic [31:0] rdVal;
        logic        checkVal;
        logic        addrErr;
    } wbExp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        checkData;
    } busExp_t;

    wbExp_t  wbQ[$];
    busExp_t busQ[$];

    int          checks = 0;
    int          failures = 0;
    bit          monEn = 1'b0;
    bit          respEn = 1'b1;
    bit          pendingFire = 1'b0;
    bit          busSeen = 1'b0;
    int          ackDelay = 0;
    int          ackCnt = 0;
    logic [31:0] ackRdata = '0;
    busExp_t     firstBus;
    wbExp_t      monExp;
    busExp_t     busExp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on little-endian byte lanes.
    function automatic logic [31:0] modelLoad(input int op, input int lane, input bit ext,
                                              input logic [31:0] rdata);
        int unsigned v;
        v = rdata;
        if (op == 1) begin
            v = (rdata >> (8 * lane)) & 32'hFF;
            if (ext && v >= 128) v = v + 32'hFFFFFF00;
        end else if (op == 2) begin
            v = (rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
            if (ext && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] modelBen(input int op, input int lane);
        if (op == 1) return 4'(1 << lane);
        if (op == 2) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] modelWdata(input int op, input logic [31:0] d);
        if (op == 1) return (d & 32'hFF) * 32'h01010101;
        if (op == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic setOther(input bit s);
        int which;
        i_exec_stall  = 1'b0;
        i_fetch_stall = 1'b0;
        i_wait_stall  = 1'b0;
        if (s) begin
            which = $urandom_range(0, 2);
            if (which == 0) i_exec_stall = 1'b1;
            else if (which == 1) i_fetch_stall = 1'b1;
            else i_wait_stall = 1'b1;
        end
    endtask

    // Presents one instruction until the pipeline consumes it. hold/doneHold
    // are cycles of foreign stall before issue and while finishing.
    task automatic applyStimulus(input int op, input bit lns, input bit ext,
                                 input logic [31:0] alu, input logic [31:0] data,
                                 input logic [4:0] rdNo, input logic [31:0] rdata,
                                 input int hold, input int delay, input int doneHold);
        wbExp_t  w;
        busExp_t b;
        bit      isTrap;
        bit      consumed;
        bit      fire;
        bit      other;
        int      lane;
        int      expStall;
        int      cyc;
        int      stallCnt;
        int      doneAt;
        lane   = int'(alu[1:0]);
        isTrap = 1'b0;
`ifdef UPARC_LSU_MISALIGN_TRAP_EN
        isTrap = (op == 2 && (lane % 2) == 1) || (op == 3 && lane != 0);
`endif
        w.addrErr = 1'b0;
        if (op == 0) begin
            w.rdNo = rdNo; w.rdVal = alu; w.checkVal = 1'b1;
            expStall = 0;
        end else if (isTrap) begin
            w.rdNo = 5'd0; w.rdVal = '0; w.checkVal = 1'b0; w.addrErr = 1'b1;
            expStall = 0;
        end else begin
            b.addr      = alu & 32'hFFFFFFFC;
            b.wr        = lns;
            b.ben       = lns ? modelBen(op, lane) : 4'hF;
            b.wdata     = modelWdata(op, data);
            b.checkData = lns;
            busQ.push_back(b);
            w.rdNo     = lns ? 5'd0 : rdNo;
            w.rdVal    = modelLoad(op, lane, ext, rdata);
            w.checkVal = !lns;
            expStall   = hold + delay + 2;
        end
        wbQ.push_back(w);
        ackDelay = delay;
        ackRdata = rdata;
        doneAt   = hold + delay + 2;
        consumed = 1'b0;
        cyc      = 0;
        stallCnt = 0;
        while (!consumed && cyc < 64) begin
            i_lsu_op     = 2'(op);
            i_lsu_lns    = lns;
            i_lsu_ext    = ext;
            i_alu_result = alu;
            i_mem_data   = data;
            i_rd_no      = rdNo;
            other = (cyc < hold);
            if (op != 0 && !isTrap)
                other = other || (cyc > hold && cyc < doneAt && $urandom_range(0, 1) == 1)
                              || (cyc >= doneAt && cyc < doneAt + doneHold);
            setOther(other);
            @(negedge clk);
            if (o_mem_stall) stallCnt++;
            fire = !(i_exec_stall | i_fetch_stall | i_wait_stall | o_mem_stall);
            @(posedge clk);
            #1;
            cyc++;
            consumed = fire;
        end
        if (!consumed) begin
            checks++;
            failures++;
            $display("[TB] FAIL consume actual=timeout expected=consumed op=%0d addr=%h", op, alu);
        end
        checkOutput("memStall cycles", stallCnt, expStall);
        i_lsu_op = 2'd0;
        setOther(1'b0);
        i_exec_stall = 1'b1;
    endtask

    // Writeback monitor: one register update per consumed instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (pendingFire) begin
                if (wbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL wbQueue actual=update expected=no-entry");
                end else begin
                    monExp = wbQ.pop_front();
                    checkOutput("wb rdNo", o_rd_no, monExp.rdNo);
                    if (monExp.checkVal) checkOutput("wb rdVal", o_rd_val, monExp.rdVal);
                    checkOutput("wb addrErr", o_addr_error, monExp.addrErr);
                end
            end
            pendingFire = monEn && !(i_exec_stall | i_fetch_stall | i_wait_stall | o_mem_stall);
        end
    end

    // Bus responder and bus-side monitor.
    initial begin
        i_bus_ack   = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (respEn) begin
                i_bus_ack = 1'b0;
                if (o_bus_req) begin
                    if (!busSeen) begin
                        busSeen  = 1'b1;
                        ackCnt   = ackDelay;
                        firstBus = {o_bus_addr, o_bus_wr, o_bus_ben, o_bus_wdata, 1'b0};
                        if (busQ.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL busQueue actual=request expected=no-entry addr=%h", o_bus_addr);
                        end else begin
                            busExp = busQ.pop_front();
                            checkOutput("bus addr", o_bus_addr, busExp.addr);
                            checkOutput("bus wr", 32'(o_bus_wr), 32'(busExp.wr));
                            checkOutput("bus ben", 32'(o_bus_ben), 32'(busExp.ben));
                            if (busExp.checkData) checkOutput("bus wdata", o_bus_wdata, busExp.wdata);
                        end
                    end
                    if (ackCnt == 0) begin
                        checkOutput("bus addr stable", o_bus_addr, firstBus.addr);
                        checkOutput("bus ctl stable", {27'd0, o_bus_wr, o_bus_ben},
                                    {27'd0, firstBus.wr, firstBus.ben});
                        checkOutput("bus wdata stable", o_bus_wdata, firstBus.wdata);
                        i_bus_ack   = 1'b1;
                        i_bus_rdata = ackRdata;
                        busSeen     = 1'b0;
                    end else begin
                        ackCnt--;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_lsu_op = 2'd0; i_lsu_lns = 1'b0; i_lsu_ext = 1'b0;
        i_alu_result = '0; i_mem_data = '0; i_rd_no = '0;
        i_exec_stall = 1'b1; i_fetch_stall = 1'b0; i_wait_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busReq", 32'(o_bus_req), 0);
        checkOutput("reset rdNo", 32'(o_rd_no), 0);
        checkOutput("reset rdVal", o_rd_val, 0);
        checkOutput("reset addrErr", 32'(o_addr_error), 0);
        checkOutput("reset ben", 32'(o_bus_ben), 0);
        checkOutput("reset addr", o_bus_addr, 0);
        checkOutput("reset memStall", 32'(o_mem_stall), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        monEn = 1'b1;

        applyStimulus(0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h0000_0103, 32'h0, 5'd9, 32'h80FF_FF7F, 0, 0, 0);
        applyStimulus(2, 0, 0, 32'h0000_0102, 32'h0, 5'd10, 32'hBEEF_1234, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h0000_0201, 32'hAABB_CCDD, 5'd11, 32'h0, 0, 3, 0);
        applyStimulus(3, 0, 0, 32'h0000_0302, 32'h0, 5'd12, 32'h1122_3344, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        @(negedge clk);
        #1;
        monEn = 1'b0;
        checkOutput("wbQ drained", wbQ.size(), 0);
        checkOutput("busQ drained", busQ.size(), 0);

        // Reset in the middle of a bus transaction; the late ack must be ignored.
        @(posedge clk);
        #1;
        respEn = 1'b0;
        i_bus_ack = 1'b0;
        i_lsu_op = 2'd3; i_lsu_lns = 1'b0; i_alu_result = 32'h0000_0400; i_rd_no = 5'd3;
        i_exec_stall = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstTest busReq issued", 32'(o_bus_req), 1);
        i_exec_stall = 1'b1;
        i_lsu_op = 2'd0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstTest busReq dropped", 32'(o_bus_req), 0);
        checkOutput("rstTest memStall", 32'(o_mem_stall), 0);
        checkOutput("rstTest rdNo", 32'(o_rd_no), 0);
        checkOutput("rstTest rdVal", o_rd_val, 0);
        checkOutput("rstTest ben", 32'(o_bus_ben), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        i_bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("rstTest lateAck busReq", 32'(o_bus_req), 0);
        checkOutput("rstTest lateAck memStall", 32'(o_mem_stall), 0);
        checkOutput("rstTest lateAck rdNo", 32'(o_rd_no), 0);
        checkOutput("rstTest lateAck rdVal", o_rd_val, 0);
        respEn = 1'b1;

        @(posedge clk);
        #1;
        monEn = 1'b1;
        applyStimulus(0, 0, 0, 32'hCAFE_F00D, 32'h0, 5'd7, 32'h0, 0, 0, 0);
        applyStimulus(2, 0, 1, 32'h0000_0502, 32'h0, 5'd8, 32'h8001_7FFF, 1, 1, 1);
        @(negedge clk);
        #1;
        checkOutput("final wbQ drained", wbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
